mole_round_ctrl: RTL
====================

MOLE_ROUND_CTRL -- requirements
Module: mole_round_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  single-cycle request to begin or restart a game.
REQ-004 SHALL have port: hit_valid  input  1  one-cycle strobe when a player presses a hole.
REQ-005 SHALL have port: hit_pos  input  4  index of the pressed hole, 0..8.
REQ-006 SHALL have port: timeout  input  1  one-cycle expiry pulse from the interval counter.
REQ-007 SHALL have port: cnt_rst_n  output  1  active-low reload strobe to the interval counter.
REQ-008 SHALL have port: interval  output  3  seconds loaded into the interval counter, 1..7.
REQ-009 SHALL have port: dir  output  1  count direction to the interval counter; constant 0 (down).
REQ-010 SHALL have port: mole_pos  output  4  active mole hole, 0..8.
REQ-011 SHALL have port: mole_on  output  1  mole currently visible.
REQ-012 SHALL have port: score  output  8  hits this game, saturating at 255.
REQ-013 SHALL have port: misses  output  2  timeouts this game.
REQ-014 SHALL have port: game_over  output  1  high while in OVER.

Function
REQ-015 SHALL implement FSM states IDLE, ARM, WAIT, HIT, MISS, OVER; all outputs registered.
REQ-016 SHALL run an 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1) that advances every cycle outside reset.
REQ-017 SHALL, in IDLE, hold mole_on=0 and cnt_rst_n=1, and go to ARM on start.
REQ-018 SHALL, in ARM (exactly 1 cycle), drive cnt_rst_n=0 and latch interval and mole_pos; next state WAIT.
REQ-019 SHALL derive interval from lfsr[6:4], replacing 0 with 1.
REQ-020 SHALL derive mole_pos as p=lfsr[3:0] (p-9 if p>=9); if that equals the previous mole_pos, use (p+1) mod 9 instead.
REQ-021 SHALL hold interval stable from ARM until the next ARM.
REQ-022 SHALL, in WAIT, drive mole_on=1 and cnt_rst_n=1.
REQ-023 SHALL, in WAIT, go to HIT on hit_valid with hit_pos==mole_pos.
REQ-024 SHALL, in WAIT, go to MISS on timeout when REQ-023 does not apply.
REQ-025 SHALL, in WAIT, ignore hit_valid with a non-matching or out-of-range hit_pos.
REQ-026 SHALL let the hit win when a matching hit and timeout coincide; misses unchanged.
REQ-027 SHALL, in HIT (1 cycle), set mole_on=0 and score=score+1, saturating at 255; next state ARM.
REQ-028 SHALL, in MISS (1 cycle), set mole_on=0 and misses=misses+1; next state OVER if new misses==`MAX_MISSES (3), else ARM.
REQ-029 SHALL, in OVER, hold score and misses, set game_over=1 and mole_on=0, and ignore hits and timeouts.
REQ-030 SHALL, on start in OVER, clear score and misses, set game_over=0, and go to ARM.
REQ-031 SHALL ignore start in ARM, WAIT, HIT and MISS.
REQ-032 SHALL make the latency from a matching hit_valid to mole_on=0 one cycle, and to the next cnt_rst_n=0 two cycles.

Reset
REQ-033 SHALL, while rst=1, force state=IDLE, score=0, misses=0, mole_on=0, mole_pos=0, interval=0, cnt_rst_n=1, dir=0, game_over=0, LFSR=`LFSR_SEED (8'hA5).
REQ-034 SHALL let rst asserted mid-game (any state) abandon the round in the same edge; no HIT or MISS update occurs.

Structure
REQ-035 SHALL take `MAX_MISSES, `NUM_HOLES (9) and `LFSR_SEED from the shared defines.vh alongside `CLK_FREQ.
REQ-036 SHALL place the LFSR in one sub-module, mole_lfsr (clk, rst, 8-bit state out).
REQ-037 SHALL NOT instantiate interval_counter; the integration top connects the two blocks.

Verification
REQ-038 SHALL cover reset: rst=1 for 2 cycles -> IDLE, score=0, misses=0, mole_on=0, cnt_rst_n=1, interval=0.
REQ-039 SHALL cover start: 1-cycle start pulse -> cnt_rst_n=0 for exactly 1 cycle, interval in 1..7, mole_pos in 0..8, mole_on=1 the following cycle.
REQ-040 SHALL cover a correct hit: in WAIT, hit_valid with hit_pos=mole_pos -> score 0->1, mole_on=0 next cycle, new ARM with mole_pos different from the previous one.
REQ-041 SHALL cover a wrong hit then timeout: hit_pos=mole_pos+1 -> no change; then timeout -> misses 0->1, new round.
REQ-042 SHALL cover game over: 3 timeouts -> game_over=1, later hits ignored; then start -> score=0, misses=0, ARM.
REQ-043 SHALL cover edge cases: hit and timeout in the same cycle -> score+1 and misses unchanged; score=255 plus a hit -> 255; rst in WAIT -> IDLE next edge.

Source files
------------

// File: rtl/mole_round_ctrl_pkg.sv
// Shared constants, state encoding and mole placement helpers for the
// whack-a-mole round controller.
package mole_round_ctrl_pkg;

  localparam int unsigned NUM_HOLES  = 9;
  localparam int unsigned MAX_MISSES = 3;
  localparam int unsigned LFSR_W     = 8;
  localparam int unsigned POS_W      = 4;
  localparam int unsigned INT_W      = 3;
  localparam int unsigned SCORE_W    = 8;
  localparam int unsigned MISS_W     = 2;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;
  // Right-shift Galois feedback mask for x^8+x^6+x^5+x^4+1
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT,
    HIT,
    MISS,
    OVER
  } state_e;

  // Interval seconds from lfsr[6:4]; zero is promoted to one.
  function automatic logic [INT_W-1:0] pick_interval(input logic [6:0] rnd);
    return (rnd[6:4] == INT_W'(0)) ? INT_W'(1) : rnd[6:4];
  endfunction

  // Fold lfsr[3:0] into 0..8 and step past the previous hole on a repeat.
  function automatic logic [POS_W-1:0] pick_pos(input logic [6:0]       rnd,
                                                input logic [POS_W-1:0] prev);
    logic [POS_W-1:0] p;
    p = rnd[3:0];
    if (p >= POS_W'(NUM_HOLES)) p = p - POS_W'(NUM_HOLES);
    if (p == prev) p = (p == POS_W'(NUM_HOLES - 1)) ? POS_W'(0) : p + POS_W'(1);
    return p;
  endfunction

endpackage

// File: rtl/mole_round_ctrl_if.sv
// Player/counter side signals of the round controller.
interface mole_round_ctrl_if;
  import mole_round_ctrl_pkg::*;

  logic               start;
  logic               hit_valid;
  logic [POS_W-1:0]   hit_pos;
  logic               timeout;
  logic               cnt_rst_n;
  logic [INT_W-1:0]   interval;
  logic               dir;
  logic [POS_W-1:0]   mole_pos;
  logic               mole_on;
  logic [SCORE_W-1:0] score;
  logic [MISS_W-1:0]  misses;
  logic               game_over;

  modport slave (
    input  start, hit_valid, hit_pos, timeout,
    output cnt_rst_n, interval, dir, mole_pos, mole_on, score, misses, game_over
  );

  modport master (
    output start, hit_valid, hit_pos, timeout,
    input  cnt_rst_n, interval, dir, mole_pos, mole_on, score, misses, game_over
  );

endinterface

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Galois LFSR, x^8+x^6+x^5+x^4+1, reseeded by reset.
module mole_lfsr
  import mole_round_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : LFSR_W'(0));
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/mole_round_ctrl.sv
// Round controller: arms the interval counter, places the mole, scores hits
// and counts timeouts until the game ends.
module mole_round_ctrl
  import mole_round_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  mole_round_ctrl_if.slave  bus
);

  logic [LFSR_W-1:0]  lfsr;
  logic               unused_lfsr_msb;

  state_e             state_q;
  logic               cnt_rst_n_q;
  logic [INT_W-1:0]   interval_q;
  logic [POS_W-1:0]   mole_pos_q;
  logic               mole_on_q;
  logic [SCORE_W-1:0] score_q;
  logic [MISS_W-1:0]  misses_q;
  logic               game_over_q;

  logic [INT_W-1:0]   interval_d;
  logic [POS_W-1:0]   mole_pos_d;
  logic [SCORE_W-1:0] score_d;
  logic [MISS_W-1:0]  misses_d;
  logic               hit_match_c;

  mole_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .state_o (lfsr)
  );

  assign unused_lfsr_msb = lfsr[LFSR_W-1];

  // Values captured on entry to ARM, and the saturating score increment.
  always_comb begin
    interval_d  = pick_interval(lfsr[6:0]);
    mole_pos_d  = pick_pos(lfsr[6:0], mole_pos_q);
    score_d     = (score_q == {SCORE_W{1'b1}}) ? score_q : score_q + SCORE_W'(1);
    misses_d    = misses_q + MISS_W'(1);
    hit_match_c = bus.hit_valid && (bus.hit_pos == mole_pos_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_rst_n_q <= 1'b1;
      interval_q  <= '0;
      mole_pos_q  <= '0;
      mole_on_q   <= 1'b0;
      score_q     <= '0;
      misses_q    <= '0;
      game_over_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q     <= ARM;
            cnt_rst_n_q <= 1'b0;
            interval_q  <= interval_d;
            mole_pos_q  <= mole_pos_d;
          end
        end
        ARM: begin
          state_q     <= WAIT;
          cnt_rst_n_q <= 1'b1;
          mole_on_q   <= 1'b1;
        end
        // A matching hit takes priority over a coincident timeout.
        WAIT: begin
          if (hit_match_c) begin
            state_q   <= HIT;
            mole_on_q <= 1'b0;
            score_q   <= score_d;
          end else if (bus.timeout) begin
            state_q   <= MISS;
            mole_on_q <= 1'b0;
            misses_q  <= misses_d;
          end
        end
        HIT: begin
          state_q     <= ARM;
          cnt_rst_n_q <= 1'b0;
          interval_q  <= interval_d;
          mole_pos_q  <= mole_pos_d;
        end
        MISS: begin
          if (misses_q == MISS_W'(MAX_MISSES)) begin
            state_q     <= OVER;
            game_over_q <= 1'b1;
          end else begin
            state_q     <= ARM;
            cnt_rst_n_q <= 1'b0;
            interval_q  <= interval_d;
            mole_pos_q  <= mole_pos_d;
          end
        end
        OVER: begin
          if (bus.start) begin
            state_q     <= ARM;
            cnt_rst_n_q <= 1'b0;
            interval_q  <= interval_d;
            mole_pos_q  <= mole_pos_d;
            score_q     <= '0;
            misses_q    <= '0;
            game_over_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cnt_rst_n = cnt_rst_n_q;
  assign bus.interval  = interval_q;
  assign bus.dir       = 1'b0;
  assign bus.mole_pos  = mole_pos_q;
  assign bus.mole_on   = mole_on_q;
  assign bus.score     = score_q;
  assign bus.misses    = misses_q;
  assign bus.game_over = game_over_q;

endmodule
